// File: rtl/path_delay_meter.sv
// path_delay_meter: measures, in clk cycles, how long the capture signal y
// takes to follow a transition of the launch signal a.
//
// Optional build macro: PATH_DELAY_MINMAX_EN adds the dmin/dmax running
// minimum/maximum outputs. Without it those ports and their logic are absent.
//
// Handshake/pulse semantics: valid, timeout and overrun are registered,
// single-cycle pulses that appear in the cycle following the clock edge that
// decided them. delay is stable whenever valid is high and keeps its value
// until the next successful measurement. At most one pulse is high per cycle.
// busy is a direct decode of the FSM state (high only in MEASURE), so it also
// serves as the observable FSM state for checkers.
module path_delay_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             a,
  input  logic             y,
`ifdef PATH_DELAY_MINMAX_EN
  output logic [CNT_W-1:0] dmin,
  output logic [CNT_W-1:0] dmax,
`endif
  output logic [CNT_W-1:0] delay,
  output logic             valid,
  output logic             timeout,
  output logic             overrun,
  output logic             busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  // Datapath action decided by the next-state logic for the current edge.
  typedef enum logic [2:0] {
    ACT_NONE    = 3'd0,
    ACT_ZERO    = 3'd1,  // y already equals a at the launch edge
    ACT_START   = 3'd2,  // begin a new measurement
    ACT_RESTART = 3'd3,  // a toggled again mid-measurement
    ACT_DONE    = 3'd4,  // y reached the target
    ACT_TIMEOUT = 3'd5,  // gave up waiting for y
    ACT_COUNT   = 3'd6   // keep waiting
  } act_t;

  state_t           state;
  state_t           next_state;
  act_t             act;
  logic             a_q;
  logic             target;
  logic [CNT_W-1:0] cnt;
  logic             launch;
  logic             meas_done;
  logic [CNT_W-1:0] d_new;

  assign launch    = (a != a_q);
  // A successful measurement: either the zero-delay case or y catching up.
  assign meas_done = (act == ACT_ZERO) || (act == ACT_DONE);
  assign d_new     = (act == ACT_DONE) ? cnt : '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and action selection; a fresh launch edge in MEASURE wins
  // over both completion and timeout so a glitchy a never yields a bogus delay.
  always_comb begin
    next_state = state;
    act        = ACT_NONE;
    case (state)
      IDLE: begin
        if (en && launch) begin
          if (y == a) begin
            act = ACT_ZERO;
          end else begin
            act        = ACT_START;
            next_state = MEASURE;
          end
        end
      end
      MEASURE: begin
        if (launch) begin
          act = ACT_RESTART;
        end else if (y == target) begin
          act        = ACT_DONE;
          next_state = IDLE;
        end else if (cnt == TIMEOUT_C) begin
          act        = ACT_TIMEOUT;
          next_state = IDLE;
        end else begin
          act = ACT_COUNT;
        end
      end
    endcase
  end

  // Output decode: busy mirrors the MEASURE state.
  always_comb begin
    busy = (state == MEASURE);
  end

  // Datapath: launch history, target/counter and the registered result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= 1'b0;
      target  <= 1'b0;
      cnt     <= '0;
      delay   <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
      overrun <= 1'b0;
    end else begin
      a_q     <= a;
      valid   <= meas_done;
      timeout <= (act == ACT_TIMEOUT);
      overrun <= (act == ACT_RESTART);
      if (meas_done) begin
        delay <= d_new;
      end
      case (act)
        ACT_START, ACT_RESTART: begin
          target <= a;
          cnt    <= ONE_C;
        end
        // cnt never passes TIMEOUT, which is below 2^CNT_W, so it cannot wrap.
        ACT_COUNT: cnt <= cnt + ONE_C;
        default: ;
      endcase
    end
  end

`ifdef PATH_DELAY_MINMAX_EN
  // Running extremes of every successful measurement; timeouts and overruns
  // never reach here because they do not raise meas_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmin <= '1;
      dmax <= '0;
    end else if (meas_done) begin
      if (d_new < dmin) dmin <= d_new;
      if (d_new > dmax) dmax <= d_new;
    end
  end
`endif

endmodule

// File: tb/tb_path_delay_meter.sv
// Bench for path_delay_meter. Two instances share the same stimulus: u_a uses
// TIMEOUT=5 (timeout scenarios), u_b the default TIMEOUT=200 (long delays).
// The reference model tracks the launch edge index of a measurement and
// derives delay as the number of clock edges elapsed since that launch.
module tb_path_delay_meter;
  localparam int CNT_W = 8;
  localparam int TO_A  = 5;
  localparam int TO_B  = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic a   = 1'b0;
  logic y   = 1'b0;

  logic [1:0][CNT_W-1:0] d_delay;
  logic [1:0]            d_valid, d_timeout, d_overrun, d_busy;
`ifdef PATH_DELAY_MINMAX_EN
  logic [1:0][CNT_W-1:0] d_dmin, d_dmax;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  path_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TO_A)) u_a (
    .clk(clk), .rst(rst), .en(en), .a(a), .y(y),
`ifdef PATH_DELAY_MINMAX_EN
    .dmin(d_dmin[0]), .dmax(d_dmax[0]),
`endif
    .delay(d_delay[0]), .valid(d_valid[0]), .timeout(d_timeout[0]),
    .overrun(d_overrun[0]), .busy(d_busy[0])
  );

  path_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TO_B)) u_b (
    .clk(clk), .rst(rst), .en(en), .a(a), .y(y),
`ifdef PATH_DELAY_MINMAX_EN
    .dmin(d_dmin[1]), .dmax(d_dmax[1]),
`endif
    .delay(d_delay[1]), .valid(d_valid[1]), .timeout(d_timeout[1]),
    .overrun(d_overrun[1]), .busy(d_busy[1])
  );

  // ---------------- reference model ----------------
  int                    tick_n;
  logic                  a_prev;
  logic [1:0]            m_busy, m_valid, m_timeout, m_overrun, m_tgt;
  logic [1:0][CNT_W-1:0] m_delay, m_min, m_max;
  int                    m_start [2];

  function automatic int to_lim(input int i);
    return (i == 0) ? TO_A : TO_B;
  endfunction

  // Edge-indexed model: a measurement launched at edge L and completed at
  // edge k reports k-L; it is abandoned when k-L reaches the timeout.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_n    <= 0;
      a_prev    <= 1'b0;
      m_busy    <= '0;
      m_valid   <= '0;
      m_timeout <= '0;
      m_overrun <= '0;
      m_tgt     <= '0;
      m_delay   <= '0;
      m_min     <= '1;
      m_max     <= '0;
      m_start   <= '{0, 0};
    end else begin
      tick_n <= tick_n + 1;
      a_prev <= a;
      for (int i = 0; i < 2; i++) begin
        m_valid[i]   <= 1'b0;
        m_timeout[i] <= 1'b0;
        m_overrun[i] <= 1'b0;
        if (m_busy[i]) begin
          if (a != a_prev) begin
            m_overrun[i] <= 1'b1;
            m_tgt[i]     <= a;
            m_start[i]   <= tick_n + 1;
          end else if (y == m_tgt[i]) begin
            m_busy[i]  <= 1'b0;
            m_valid[i] <= 1'b1;
            m_delay[i] <= CNT_W'(tick_n + 1 - m_start[i]);
            m_min[i]   <= (CNT_W'(tick_n + 1 - m_start[i]) < m_min[i]) ?
                          CNT_W'(tick_n + 1 - m_start[i]) : m_min[i];
            m_max[i]   <= (CNT_W'(tick_n + 1 - m_start[i]) > m_max[i]) ?
                          CNT_W'(tick_n + 1 - m_start[i]) : m_max[i];
          end else if (tick_n + 1 - m_start[i] == to_lim(i)) begin
            m_busy[i]    <= 1'b0;
            m_timeout[i] <= 1'b1;
          end
        end else if (en && (a != a_prev)) begin
          if (y == a) begin
            m_valid[i] <= 1'b1;
            m_delay[i] <= '0;
            m_min[i]   <= '0;
          end else begin
            m_busy[i]  <= 1'b1;
            m_tgt[i]   <= a;
            m_start[i] <= tick_n + 1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle, a little after the active edge.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("outputs_%0d {busy,valid,timeout,overrun,delay}", i),
            32'({d_busy[i], d_valid[i], d_timeout[i], d_overrun[i], d_delay[i]}),
            32'({m_busy[i], m_valid[i], m_timeout[i], m_overrun[i], m_delay[i]}));
      check($sformatf("pulse_exclusive_%0d", i),
            32'($countones({d_valid[i], d_timeout[i], d_overrun[i]}) <= 1), 32'd1);
`ifdef PATH_DELAY_MINMAX_EN
      check($sformatf("minmax_%0d {dmin,dmax}", i),
            32'({d_dmin[i], d_dmax[i]}), 32'({m_min[i], m_max[i]}));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Toggle a, then make y follow it d edges after the launch edge.
  task automatic meas(input int d);
    a = ~a;
    tick();
    repeat (d - 1) tick();
    y = a;
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int bc;
    int tcnt;
    int tidx;
    int seen;

    repeat (2) tick();
    check("reset_delay", 32'(d_delay[0]), 32'd0);
    check("reset_valid", 32'(d_valid[0]), 32'd0);
    check("reset_busy",  32'(d_busy[0]),  32'd0);
`ifdef PATH_DELAY_MINMAX_EN
    check("reset_dmin", 32'(d_dmin[1]), 32'hFF);
`endif
    rst = 1'b0;
    tick();

    // y follows a two cycles after the launch edge.
    bc = 0;
    a = 1'b1;
    tick(); bc += int'(d_busy[0]);
    tick(); bc += int'(d_busy[0]);
    y = 1'b1;
    tick(); bc += int'(d_busy[0]);
    check("follow2_valid", 32'(d_valid[0]), 32'd1);
    check("follow2_delay", 32'(d_delay[0]), 32'd2);
    check("follow2_busy_cycles", 32'(bc), 32'd2);
    tick();
    check("follow2_single_pulse", 32'(d_valid[0]), 32'd0);

    // a and y change together: zero delay, never busy.
    a = 1'b0; y = 1'b0;
    tick();
    check("zero_valid", 32'(d_valid[0]), 32'd1);
    check("zero_delay", 32'(d_delay[0]), 32'd0);
    check("zero_busy",  32'(d_busy[0]),  32'd0);
    tick();

    // y held: u_a times out; u_b keeps waiting.
    tcnt = 0; tidx = 0;
    a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (d_timeout[0]) begin
        tcnt++;
        tidx = k;
      end
    end
    check("timeout_count", 32'(tcnt), 32'd1);
    check("timeout_cycle", 32'(tidx), 32'd6);
    check("timeout_delay_held", 32'(d_delay[0]), 32'd0);
    check("timeout_idle", 32'(d_busy[0]), 32'd0);
    y = 1'b1;
    tick();
    tick();

    // Overrun: a toggles twice, y then settles three cycles after restart.
    a = 1'b0;
    tick();
    a = 1'b1; y = 1'b0;
    tick();
    check("overrun_pulse", 32'(d_overrun[0]), 32'd1);
    check("overrun_busy",  32'(d_busy[0]),    32'd1);
    tick();
    tick();
    y = 1'b1;
    tick();
    check("overrun_valid", 32'(d_valid[0]), 32'd1);
    check("overrun_delay", 32'(d_delay[0]), 32'd3);
    tick();

    // Reset in the middle of a measurement.
    a = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_busy_a", 32'(d_busy[0]),  32'd0);
    check("rst_busy_b", 32'(d_busy[1]),  32'd0);
    check("rst_delay",  32'(d_delay[0]), 32'd0);
    check("rst_valid",  32'(d_valid[0]), 32'd0);
    tick();
    rst = 1'b0;
    y = 1'b0;
    tick();
    a = 1'b1;
    tick();
    y = 1'b1;
    tick();
    check("post_rst_valid", 32'(d_valid[0]), 32'd1);
    check("post_rst_delay", 32'(d_delay[0]), 32'd1);
    tick();

    // en low: launches ignored.
    seen = 0;
    en = 1'b0;
    a = 1'b0;
    repeat (3) begin
      tick();
      seen += int'(d_busy[0]) + int'(d_valid[0]);
    end
    check("en_low_ignored", 32'(seen), 32'd0);
    y = 1'b0;
    tick();
    // en dropping mid-measurement does not abort it.
    en = 1'b1;
    a = 1'b1;
    tick();
    en = 1'b0;
    tick();
    y = 1'b1;
    tick();
    check("en_drop_valid", 32'(d_valid[0]), 32'd1);
    check("en_drop_delay", 32'(d_delay[0]), 32'd2);
    en = 1'b1;
    tick();

    // Fresh run for running extremes: delays 4, 2, 7.
    rst = 1'b1;
    a = 1'b0; y = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    meas(4); tick();
    meas(2); tick();
    meas(7); tick();
    check("seq_delay_b", 32'(d_delay[1]), 32'd7);
    check("seq_delay_a_held", 32'(d_delay[0]), 32'd2);
`ifdef PATH_DELAY_MINMAX_EN
    check("seq_dmin_b", 32'(d_dmin[1]), 32'd2);
    check("seq_dmax_b", 32'(d_dmax[1]), 32'd7);
    check("seq_dmin_a", 32'(d_dmin[0]), 32'd2);
    check("seq_dmax_a", 32'(d_dmax[0]), 32'd4);
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
